au_issue_ctrl: RTL and testbench
================================

// Module: au_issue_ctrl
// PURPOSE
//  Request/response front end for the 32-bit arithmetic unit (AU_32b). Accepts one
//  {a,b,op} request over a valid/ready handshake, drives the AU operands/ALUop, pulses
//  the AU's active-low init for mult/div, counts the AU latency and captures s or
//  {hi,lo} into a held response. Sits between the instruction issue logic and AU_32b.
// PARAMETERS
//  WIDTH          32  operand/result width
//  ADDSUB_CYCLES  1   WAIT cycles before capturing s for add/sub (>=1)
//  MD_CYCLES      33  WAIT cycles before capturing {hi,lo} for mult/div (>=1)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  req_valid  in   1      request present
//  req_ready  out  1      block can accept (state IDLE)
//  req_a      in   WIDTH  operand a
//  req_b      in   WIDTH  operand b
//  req_op     in   2      00 add, 01 sub, 10 mult, 11 div
//  au_a       out  WIDTH  AU operand a (registered)
//  au_b       out  WIDTH  AU operand b (registered)
//  au_ALUop   out  2      AU op select (registered)
//  au_rst_n   out  1      AU init, active-low
//  au_s       in   WIDTH  AU add/sub result
//  au_hi      in   WIDTH  AU product high / remainder
//  au_lo      in   WIDTH  AU product low / quotient
//  au_zero    in   1      AU zero flag (add/sub)
//  rsp_valid  out  1      response held
//  rsp_ready  in   1      consumer accepts response
//  rsp_hi     out  WIDTH  hi result (0 for add/sub)
//  rsp_lo     out  WIDTH  lo result (s for add/sub)
//  rsp_zero   out  1      add/sub: au_zero; mult/div: {hi,lo}==0
//  rsp_err    out  1      divide by zero
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, au_a/au_b/au_ALUop/rsp_* = 0, rsp_valid 0, au_rst_n 0
//    while rst high; au_rst_n 1 from first cycle after rst drops, except ISSUE for mult/div.
//  - States IDLE -> ISSUE -> WAIT -> RESP -> IDLE. req_ready = (state==IDLE), no overlap.
//  - IDLE: on req_valid&&req_ready, register a,b,op into au_a/au_b/au_ALUop; go ISSUE.
//    Exception op=11 && req_b==0: skip AU, load rsp_hi=req_a, rsp_lo=all-ones,
//    rsp_err=1, rsp_zero=0; go RESP (rsp_valid in cycle after accept).
//  - ISSUE (1 cycle): au_rst_n=0 if op is mult/div, else 1; counter loaded with K
//    (K=ADDSUB_CYCLES for add/sub, MD_CYCLES for mult/div); go WAIT.
//  - WAIT: counter decrements each cycle; on the cycle counter==1, capture at that edge:
//    add/sub -> rsp_lo=au_s, rsp_hi=0, rsp_zero=au_zero; mult/div -> rsp_hi=au_hi,
//    rsp_lo=au_lo, rsp_zero=({au_hi,au_lo}==0); rsp_err=0; go RESP.
//  - Latency: accept edge ends cycle N; rsp_valid first high in cycle N+2+K
//    (add/sub N+3, mult/div N+35 with defaults).
//  - au_a/au_b/au_ALUop stay stable from ISSUE through end of WAIT and RESP.
//  - RESP: rsp_valid=1, rsp_* stable until rsp_valid&&rsp_ready; then IDLE next cycle,
//    rsp_valid drops. rsp_ready while not rsp_valid is ignored.
//  - req_valid during busy is ignored (not queued); requester must hold until accepted.
//  - Wrap: add/sub results modulo 2^WIDTH, no carry/overflow output.
//  - rst mid-operation (any state): IDLE next edge, in-flight result discarded, no
//    rsp_valid pulse; au_rst_n held 0 while rst high.
// TESTING
//  1. add a=5,b=7 -> rsp_valid at N+3, rsp_lo=12, rsp_hi=0, rsp_zero=0, rsp_err=0.
//  2. sub a=3,b=3 -> rsp_lo=0, rsp_zero=1; sub a=0,b=1 -> rsp_lo=32'hFFFFFFFF, zero=0.
//  3. mult a=7,b=21 -> au_rst_n low exactly 1 cycle (N+1), rsp_valid at N+35,
//     {rsp_hi,rsp_lo}=147; mult 32'hFFFFFFFF*2 -> rsp_hi=1, rsp_lo=32'hFFFFFFFE.
//  4. div a=100,b=5 -> rsp_lo=20, rsp_hi=0; div a=10,b=0 -> rsp_valid at N+1,
//     rsp_err=1, rsp_hi=10, rsp_lo=32'hFFFFFFFF, au_rst_n never low.
//  5. Backpressure: rsp_ready low 10 cycles after rsp_valid -> rsp_* stable, req_ready
//     0, second req_valid not accepted until 1 cycle after rsp handshake.
//  6. rst high at N+10 during mult -> IDLE, rsp_valid stays 0, req_ready 1 after rst
//     drops; next add 1+1 returns 2 normally.

Source files
------------

// File: rtl/au_issue_ctrl.sv
// Request/response front end for the 32-bit arithmetic unit: issues one
// {a,b,op} request to the AU, times its latency and holds the captured result.
module au_issue_ctrl #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned ADDSUB_CYCLES = 1,
  parameter int unsigned MD_CYCLES     = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic [1:0]       au_ALUop,
  output logic             au_rst_n,
  input  logic [WIDTH-1:0] au_s,
  input  logic [WIDTH-1:0] au_hi,
  input  logic [WIDTH-1:0] au_lo,
  input  logic             au_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  localparam int unsigned CNT_MAX = (ADDSUB_CYCLES > MD_CYCLES) ? ADDSUB_CYCLES : MD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] OP_DIV = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] au_a_q, au_a_d;
  logic [WIDTH-1:0] au_b_q, au_b_d;
  logic [1:0]       au_op_q, au_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_hi_q, rsp_hi_d;
  logic [WIDTH-1:0] rsp_lo_q, rsp_lo_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      au_a_q      <= '0;
      au_b_q      <= '0;
      au_op_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      au_a_q      <= au_a_d;
      au_b_q      <= au_b_d;
      au_op_q     <= au_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    au_a_d      = au_a_q;
    au_b_d      = au_b_q;
    au_op_d     = au_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // Divide by zero never reaches the AU; answer straight away.
          if ((req_op == OP_DIV) && (req_b == '0)) begin
            rsp_hi_d    = req_a;
            rsp_lo_d    = '1;
            rsp_zero_d  = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            au_a_d  = req_a;
            au_b_d  = req_b;
            au_op_d = req_op;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = au_op_q[1] ? CNT_W'(MD_CYCLES) : CNT_W'(ADDSUB_CYCLES);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d = '0;
          if (au_op_q[1]) begin
            rsp_hi_d   = au_hi;
            rsp_lo_d   = au_lo;
            rsp_zero_d = (au_hi == '0) && (au_lo == '0);
          end else begin
            rsp_hi_d   = '0;
            rsp_lo_d   = au_s;
            rsp_zero_d = au_zero;
          end
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // AU init is held low during reset and for the single ISSUE cycle of mult/div.
  assign au_rst_n  = !rst && !((state_q == S_ISSUE) && au_op_q[1]);
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign au_a      = au_a_q;
  assign au_b      = au_b_q;
  assign au_ALUop  = au_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_au_issue_ctrl.sv
// Self-checking bench for au_issue_ctrl with a behavioural AU_32b stand-in.
module tb_au_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_op;
  logic [31:0] au_a, au_b;
  logic [1:0]  au_ALUop;
  logic        au_rst_n;
  logic [31:0] au_s, au_hi, au_lo;
  logic        au_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi, rsp_lo;
  logic        rsp_zero, rsp_err, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  au_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .au_a(au_a), .au_b(au_b), .au_ALUop(au_ALUop), .au_rst_n(au_rst_n),
    .au_s(au_s), .au_hi(au_hi), .au_lo(au_lo), .au_zero(au_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
  );

  // AU stand-in: results settle immediately from the registered operands.
  logic [63:0] prod;
  always_comb begin
    prod    = {32'd0, au_a} * {32'd0, au_b};
    au_s    = au_ALUop[0] ? (au_a - au_b) : (au_a + au_b);
    au_zero = (au_s == 32'd0);
    au_hi   = 32'd0;
    au_lo   = 32'd0;
    if (au_ALUop == 2'b10) begin
      au_hi = prod[63:32];
      au_lo = prod[31:0];
    end else if (au_ALUop == 2'b11 && au_b != 32'd0) begin
      au_hi = au_a % au_b;
      au_lo = au_a / au_b;
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        err;
    int          lat;
    int          lows;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called in cycle N+1; returns cycles until rsp_valid and au_rst_n low cycles seen.
  task automatic wait_rsp(output int cyc, output int lows);
    cyc  = 1;
    lows = 0;
    while (!rsp_valid && cyc < 100) begin
      if (!au_rst_n) lows++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_req(input vec_t v, input string tag);
    int cyc, lows;
    @(negedge clk);
    chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_a     = v.a;
    req_b     = v.b;
    req_op    = v.op;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(cyc, lows);
    chk({tag, " latency"}, 64'(cyc), 64'(v.lat));
    chk({tag, " au_rst_n lows"}, 64'(lows), 64'(v.lows));
    chk({tag, " rsp_hi"}, 64'(rsp_hi), 64'(v.hi));
    chk({tag, " rsp_lo"}, 64'(rsp_lo), 64'(v.lo));
    chk({tag, " rsp_zero"}, 64'(rsp_zero), 64'(v.zero));
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'(v.err));
    if (!v.err) chk({tag, " au_a held"}, 64'(au_a), 64'(v.a));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " rsp_valid drop"}, 64'(rsp_valid), 64'd0);
    chk({tag, " idle"}, 64'(req_ready), 64'd1);
  endtask

  vec_t vecs[10];

  initial begin
    int cyc, lows;
    bit seen;
    vec_t v;

    vecs[0] = '{2'b00, 32'd5,          32'd7,  32'd0,  32'd12,         1'b0, 1'b0, 3,  0};
    vecs[1] = '{2'b01, 32'd3,          32'd3,  32'd0,  32'd0,          1'b1, 1'b0, 3,  0};
    vecs[2] = '{2'b01, 32'd0,          32'd1,  32'd0,  32'hFFFFFFFF,   1'b0, 1'b0, 3,  0};
    vecs[3] = '{2'b00, 32'hFFFFFFFF,   32'd1,  32'd0,  32'd0,          1'b1, 1'b0, 3,  0};
    vecs[4] = '{2'b10, 32'd7,          32'd21, 32'd0,  32'd147,        1'b0, 1'b0, 35, 1};
    vecs[5] = '{2'b10, 32'hFFFFFFFF,   32'd2,  32'd1,  32'hFFFFFFFE,   1'b0, 1'b0, 35, 1};
    vecs[6] = '{2'b10, 32'd0,          32'd5,  32'd0,  32'd0,          1'b1, 1'b0, 35, 1};
    vecs[7] = '{2'b11, 32'd100,        32'd5,  32'd0,  32'd20,         1'b0, 1'b0, 35, 1};
    vecs[8] = '{2'b11, 32'd7,          32'd2,  32'd1,  32'd3,          1'b0, 1'b0, 35, 1};
    vecs[9] = '{2'b11, 32'd10,         32'd0,  32'd10, 32'hFFFFFFFF,   1'b0, 1'b1, 1,  0};

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset au_rst_n", 64'(au_rst_n), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset au_a", 64'(au_a), 64'd0);
    chk("reset rsp_lo", 64'(rsp_lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset au_rst_n", 64'(au_rst_n), 64'd1);

    for (int i = 0; i < 10; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Backpressure with a competing request held during RESP.
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'd20; req_b = 32'd22; req_op = 2'b00;
    @(negedge clk);
    req_a = 32'd1; req_b = 32'd2;
    wait_rsp(cyc, lows);
    chk("bp latency", 64'(cyc), 64'd3);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_lo !== 32'd42 || rsp_hi !== 32'd0 ||
          req_ready !== 1'b0 || au_a !== 32'd20) seen = 1'b1;
      @(negedge clk);
    end
    chk("bp held stable", 64'(seen), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp release rsp_valid", 64'(rsp_valid), 64'd0);
    chk("bp release req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp second accepted", 64'(busy), 64'd1);
    wait_rsp(cyc, lows);
    chk("bp second latency", 64'(cyc), 64'd3);
    chk("bp second rsp_lo", 64'(rsp_lo), 64'd3);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during a multiply discards the result.
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'd7; req_b = 32'd21; req_op = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst au_rst_n", 64'(au_rst_n), 64'd0);
    chk("midrst rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst req_ready", 64'(req_ready), 64'd1);
    chk("midrst au_rst_n release", 64'(au_rst_n), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("midrst no rsp", 64'(seen), 64'd0);
    v = '{2'b00, 32'd1, 32'd1, 32'd0, 32'd2, 1'b0, 1'b0, 3, 0};
    do_req(v, "after rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached expected finish");
    $fatal(1);
  end

endmodule
